// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared types and defaults for the handshake receive FIFO
package hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_t;

    localparam int HS_DATA_W = 4;
    localparam int HS_DEPTH  = 4;

endpackage

// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - show-ahead FIFO with push/pop/full interface and occupancy count
import hs_pkg::*;

module hs_fifo #(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = HS_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              do_push;
    logic              do_pop;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign rdata   = valid ? mem[rptr] : '0;

    // Pointers wrap naturally at DEPTH; count tracks occupancy with push and pop cancelling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: unread entries are masked by valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/hs_rx_fifo.sv
// rtl/hs_rx_fifo.sv - 4-phase send/ack receiver into a FIFO; RX_SYNC_EN adds a 2-flop send synchroniser
import hs_pkg::*;

module hs_rx_fifo #(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = HS_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              rx_clock,
    input  logic              rx_reset,
    input  logic              rx_send,
    input  logic [DATA_W-1:0] rx_dados,
    output logic              rx_ack,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rx_count,
    output logic              rx_err
);

    hs_state_t state;
    logic      send_s;
    logic      pending;
    logic      full;
    logic      push;

`ifdef RX_SYNC_EN
    logic send_meta;
    logic send_sync;

    // Two-flop synchroniser for a sender in another clock domain.
    always_ff @(posedge rx_clock or negedge rx_reset) begin
        if (!rx_reset) begin
            send_meta <= 1'b0;
            send_sync <= 1'b0;
        end else begin
            send_meta <= rx_send;
            send_sync <= send_meta;
        end
    end

    assign send_s = send_sync;
`else
    assign send_s = rx_send;
`endif

    // A word is written only on the IDLE edge that accepts it; full is the pre-edge value.
    assign push = (state == IDLE) && send_s && !full;

    // Handshake FSM with registered ack, stalled-request tracking and sticky error.
    always_ff @(posedge rx_clock or negedge rx_reset) begin
        if (!rx_reset) begin
            state   <= IDLE;
            rx_ack  <= 1'b0;
            pending <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_s && !full) begin
                        state   <= ACK;
                        rx_ack  <= 1'b1;
                        pending <= 1'b0;
                    end else if (send_s) begin
                        pending <= 1'b1;
                    end else if (pending) begin
                        rx_err  <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                ACK: begin
                    if (!send_s) begin
                        state  <= IDLE;
                        rx_ack <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rx_ack <= 1'b0;
                end
            endcase
        end
    end

    hs_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk    (rx_clock),
        .rst_n  (rx_reset),
        .push   (push),
        .pop    (rd_en),
        .wdata  (rx_dados),
        .rdata  (rd_data),
        .valid  (rd_valid),
        .full   (full),
        .count  (rx_count)
    );

endmodule

// File: tb/tb_hs_rx_fifo.sv
// tb/tb_hs_rx_fifo.sv - directed and random checks of hs_rx_fifo against a queue model
module tb_hs_rx_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
`ifdef RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              rx_clock = 1'b0;
    logic              rx_reset = 1'b0;
    logic              rx_send  = 1'b0;
    logic [DATA_W-1:0] rx_dados = '0;
    logic              rx_ack;
    logic              rd_en    = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  rx_count;
    logic              rx_err;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] q [$];
    bit                model_err = 0;

    always #5 rx_clock = ~rx_clock;

    hs_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .rx_clock (rx_clock),
        .rx_reset (rx_reset),
        .rx_send  (rx_send),
        .rx_dados (rx_dados),
        .rx_ack   (rx_ack),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rx_count (rx_count),
        .rx_err   (rx_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rx_clock);
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [DATA_W-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk({tag, "_count"}, 32'(rx_count), 32'(q.size()));
        chk({tag, "_valid"}, 32'(rd_valid), 32'(q.size() != 0));
        chk({tag, "_data"},  32'(rd_data),  32'(head));
        chk({tag, "_err"},   32'(rx_err),   32'(model_err));
    endtask

    task automatic wait_ack(input logic level, output int n);
        n = 0;
        while (rx_ack !== level && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic xfer(input logic [DATA_W-1:0] d);
        int n;
        rx_dados = d;
        rx_send  = 1'b1;
        wait_ack(1'b1, n);
        chk("ack_rise_lat", 32'(n), 32'(LAT));
        q.push_back(d);
        step();
        rx_send = 1'b0;
        wait_ack(1'b0, n);
        chk("ack_fall_lat", 32'(n), 32'(LAT));
    endtask

    task automatic pop(input string tag);
        chk({tag, "_head"}, 32'(rd_data), 32'((q.size() != 0) ? q[0] : '0));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    initial begin
        int n;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_order [4];

        // Reset state
        #2;
        rx_reset = 1'b0;
        #1;
        chk("rst_ack", 32'(rx_ack), 32'd0);
        check_state("rst");
        step();
        rx_reset = 1'b1;
        step();

        // Single transfer of 4'hA with ack rise/fall latencies
        rx_dados = 4'hA;
        rx_send  = 1'b1;
        wait_ack(1'b1, n);
        chk("single_rise", 32'(n), 32'(LAT));
        q.push_back(4'hA);
        step();
        step();
        rx_send = 1'b0;
        wait_ack(1'b0, n);
        chk("single_fall", 32'(n), 32'(LAT));
        check_state("single");
        chk("single_data", 32'(rd_data), 32'h0000000A);
        pop("single_pop");

        // Fill with 1..4, then a fifth is stalled until a pop frees space
        for (int i = 1; i <= 4; i++) xfer(DATA_W'(i));
        check_state("fill4");
        rx_dados = 4'h5;
        rx_send  = 1'b1;
        repeat (LAT + 3) step();
        chk("full_no_ack", 32'(rx_ack), 32'd0);
        chk("full_count", 32'(rx_count), 32'd4);
        pop("bp_pop");
        chk("bp_same_edge_ack", 32'(rx_ack), 32'd0);
        chk("bp_same_edge_cnt", 32'(rx_count), 32'd3);
        step();
        chk("bp_next_edge_ack", 32'(rx_ack), 32'd1);
        q.push_back(4'h5);
        rx_send = 1'b0;
        wait_ack(1'b0, n);
        chk("bp_fall", 32'(n), 32'(LAT));
        check_state("bp");
        exp_order[0] = 4'h2; exp_order[1] = 4'h3;
        exp_order[2] = 4'h4; exp_order[3] = 4'h5;
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", 32'(rd_data), 32'(exp_order[i]));
            pop("bp_drain");
        end
        check_state("bp_empty");

        // Sender abandons a stalled request on a full FIFO
        while (q.size() < DEPTH) xfer(DATA_W'($urandom_range(0, 15)));
        rx_dados = 4'hE;
        rx_send  = 1'b1;
        repeat (LAT + 3) step();
        chk("abandon_no_ack", 32'(rx_ack), 32'd0);
        rx_send = 1'b0;
        repeat (LAT + 2) step();
        model_err = 1;
        check_state("abandon");
        pop("abandon_pop");
        xfer(4'h6);
        check_state("err_sticky");

        // Push and pop on the same edge at count 2
        while (q.size() > 2) pop("pp_trim");
        while (q.size() < 2) xfer(DATA_W'($urandom_range(0, 15)));
        d = 4'hC;
        rx_dados = d;
        rx_send  = 1'b1;
        repeat (LAT - 1) step();
        chk("pp_head", 32'(rd_data), 32'(q[0]));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("pp_ack", 32'(rx_ack), 32'd1);
        void'(q.pop_front());
        q.push_back(d);
        check_state("pp");
        rx_send = 1'b0;
        wait_ack(1'b0, n);
        chk("pp_fall", 32'(n), 32'(LAT));

        // Read while empty is ignored
        while (q.size() > 0) pop("empty_drain");
        rd_en = 1'b1;
        repeat (2) step();
        rd_en = 1'b0;
        check_state("rd_empty");

        // Random mix of transfers and pops
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0 && q.size() < DEPTH) begin
                xfer(DATA_W'($urandom_range(0, 15)));
            end else begin
                pop("rnd_pop");
            end
            check_state("rnd");
        end

        // Asynchronous reset mid-ACK with two words buffered
        while (q.size() > 0) pop("mr_drain");
        xfer(4'h1);
        xfer(4'h2);
        rx_dados = 4'h9;
        rx_send  = 1'b1;
        wait_ack(1'b1, n);
        chk("mr_ack_up", 32'(rx_ack), 32'd1);
        #2;
        rx_reset = 1'b0;
        #1;
        chk("mr_ack", 32'(rx_ack), 32'd0);
        chk("mr_valid", 32'(rd_valid), 32'd0);
        chk("mr_count", 32'(rx_count), 32'd0);
        q.delete();
        model_err = 0;
        check_state("mr");
        rx_send = 1'b0;
        step();
        rx_reset = 1'b1;
        step();
        xfer(4'h7);
        check_state("post_rst");
        pop("post_rst_pop");
        check_state("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hs_rx_fifo.md
Name: hs_rx_fifo

Overview:
- Parametrised successor to the single-word peripheral receiver.
- Accepts words from a CPU-side sender over a 4-phase send/ack handshake and buffers them in a DEPTH-entry FIFO.
- Presents the words to a local consumer through a show-ahead read port.
- Applies backpressure by withholding ack when full, and flags sender protocol violations.

Parameters:
- DATA_W, 4: width of transferred word.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_W, log2(DEPTH)+1: width of occupancy count.

Ports:
- rx_clock  in  1  single clock; all logic on rising edge.
- rx_reset  in  1  asynchronous, active-low reset.
- rx_send  in  1  sender request; word valid on rx_dados while high.
- rx_dados  in  DATA_W  word from sender.
- rx_ack  out  1  registered acknowledge to sender.
- rd_en  in  1  consumer pops head word.
- rd_data  out  DATA_W  head word; valid when rd_valid = 1.
- rd_valid  out  1  FIFO non-empty.
- rx_count  out  CNT_W  current occupancy, 0..DEPTH.
- rx_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rx_reset = 0, asynchronous): state IDLE, rx_ack 0, pointers 0, rx_count 0, rd_valid 0, rd_data 0, rx_err 0. Takes effect mid-transfer; any buffered words are discarded.
- FSM states: IDLE, ACK. rx_ack = (state == ACK), registered.
- IDLE, rx_send = 1, rx_count < DEPTH: write rx_dados into FIFO on this edge, go to ACK. rx_ack is high the following cycle (1-cycle latency).
- IDLE, rx_send = 1, rx_count == DEPTH: no write; stay IDLE (stall). Remember a pending request.
- IDLE, pending request, rx_send falls before the word was accepted: set rx_err; clear pending.
- ACK, rx_send = 1: hold ACK (no further writes).
- ACK, rx_send = 0: go to IDLE; rx_ack low the next cycle.
- Exactly one word is written per send/ack cycle. A new word needs rx_send low for at least one sampled edge.
- Full check uses the pre-edge rx_count. A pop and a blocked push in the same cycle do not let the push through; the write happens on the next edge.
- Pop: rd_en = 1 with rd_valid = 1 advances the read pointer. rd_en with FIFO empty is ignored: no underflow, no error.
- Simultaneous push and pop: rx_count unchanged; data order preserved.
- Pointers wrap modulo DEPTH. rx_count never exceeds DEPTH.
- rd_data is the head entry, combinational from storage (show-ahead). It is 0 when empty.
- rx_err is cleared only by reset.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined: rx_send passes through a 2-flop synchroniser before the FSM, for senders in another clock domain. Send-to-ack latency becomes 3 cycles and release latency 3 cycles. Data is captured when the synchronised send is seen high; the protocol guarantees rx_dados is stable then.
- Undefined: rx_send is used directly; latencies as in Behaviour.

Decomposition:
- Package hs_pkg: state enum typedef (IDLE, ACK), default DATA_W/DEPTH constants.
- Sub-module hs_fifo: storage, read/write pointers, count, rd_data/rd_valid. Has push/pop/full interface.
- hs_rx_fifo contains the FSM, error logic, optional synchroniser, and one hs_fifo instance.

Test Plan:
- Reset mid-ACK with 2 words buffered -> rx_ack 0, rd_valid 0, rx_count 0 immediately, without waiting for a clock edge.
- Single transfer rx_dados = 4'hA, send high at edge 0 -> rx_ack high after edge 0; drop send at edge 3 -> rx_ack low after edge 3; rd_data = 4'hA, rx_count 1.
- Four transfers 1,2,3,4 with no reads, then fifth transfer 5 -> rx_ack stays low. Pop once -> 5 is accepted on the next edge; read order 2,3,4,5.
- Full FIFO, sender drops rx_send without ack -> rx_err = 1 and stays 1 through later good transfers.
- Push and pop in the same cycle at rx_count 2 -> rx_count stays 2, next rd_data is the correct next word. rd_en while empty -> no change.
- With RX_SYNC_EN, single transfer of 4'h7 -> rx_ack rises 3 cycles after rx_send; word 7 read back correctly.
